// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the mini CPU control sequencer: opcodes, FSM states,
// instruction classes and the bundle of datapath strobes.
package cpu_ctrl_pkg;

   localparam int OP_LD   = 0;
   localparam int OP_LDI  = 1;
   localparam int OP_ST   = 2;
   localparam int OP_ADD  = 3;
   localparam int OP_SUB  = 4;
   localparam int OP_AND  = 5;
   localparam int OP_OR   = 6;
   localparam int OP_SHR  = 7;
   localparam int OP_SHRA = 8;
   localparam int OP_SHL  = 9;
   localparam int OP_ROR  = 10;
   localparam int OP_ROL  = 11;
   localparam int OP_ADDI = 12;
   localparam int OP_ANDI = 13;
   localparam int OP_ORI  = 14;
   localparam int OP_MUL  = 15;
   localparam int OP_DIV  = 16;
   localparam int OP_NEG  = 17;
   localparam int OP_NOT  = 18;
   localparam int OP_BR   = 19;
   localparam int OP_JR   = 20;
   localparam int OP_JAL  = 21;
   localparam int OP_IN   = 22;
   localparam int OP_OUT  = 23;
   localparam int OP_MFHI = 24;
   localparam int OP_MFLO = 25;
   localparam int OP_NOP  = 26;
   localparam int OP_HALT = 27;

   typedef enum logic [3:0] {
      S_RST, S_F0, S_F1, S_F2, S_F3,
      S_T3, S_T4, S_T5, S_T6, S_T7,
      S_PAUSE, S_HALT
   } state_t;

   typedef enum logic [4:0] {
      C_ALU_R, C_ALU_I, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
      C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL
   } op_class_t;

   typedef struct packed {
      logic gra, grb, grc, rin, rout, baout, cout, lnk;
      logic pcout, pcin, incpc, marin, mdrin, mdrout, irin, yin;
      logic zlowin, zhighin, zlowout, zhighout, hiin, hiout, loin, loout;
      logic conin, inportout, outportin, read, write;
   } strobe_t;

   // Steps that talk to memory and may be stretched by the ready handshake.
   function automatic logic is_mem_step(state_t s, op_class_t c);
      return (s == S_F2) || (s == S_T6 && c == C_LD) || (s == S_T7 && c == C_ST);
   endfunction

endpackage

// File: rtl/cpu_control_seq_if.sv
// Bundle between the control sequencer and the datapath: instruction, status
// inputs and every control strobe.
interface cpu_control_seq_if #(
   parameter int IR_W = 32
);
   logic [IR_W-1:0] IR;
   logic Con_FF, Mem_ready, Stop;
   logic Clear, Run, Illegal;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Lnk;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin;
   logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
   logic CONin, InPortout, OutPortin, Read, Write;

   modport master (
      output IR, Con_FF, Mem_ready, Stop,
      input  Clear, Run, Illegal,
      input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, Lnk,
      input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
      input  Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
      input  CONin, InPortout, OutPortin, Read, Write
   );

   modport slave (
      input  IR, Con_FF, Mem_ready, Stop,
      output Clear, Run, Illegal,
      output Gra, Grb, Grc, Rin, Rout, BAout, Cout, Lnk,
      output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
      output Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
      output CONin, InPortout, OutPortin, Read, Write
   );
endinterface

// File: rtl/cpu_op_class.sv
// Combinational opcode to instruction-class decode; any opcode not listed
// is reported as ILLEGAL.
module cpu_op_class
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 5
) (
   input  logic [OPC_W-1:0] opc,
   output op_class_t        cls
);

   always_comb begin
      cls = C_ILLEGAL;
      case (int'(opc))
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  cls = C_ALU_R;
         OP_ADDI, OP_ANDI, OP_ORI:         cls = C_ALU_I;
         OP_NEG, OP_NOT:                   cls = C_UNARY;
         OP_MUL, OP_DIV:                   cls = C_MULDIV;
         OP_LD:                            cls = C_LD;
         OP_LDI:                           cls = C_LDI;
         OP_ST:                            cls = C_ST;
         OP_BR:                            cls = C_BR;
         OP_JR:                            cls = C_JR;
         OP_JAL:                           cls = C_JAL;
         OP_IN:                            cls = C_IN;
         OP_OUT:                           cls = C_OUT;
         OP_MFHI:                          cls = C_MFHI;
         OP_MFLO:                          cls = C_MFLO;
         OP_NOP:                           cls = C_NOP;
         OP_HALT:                          cls = C_HALT;
         default:                          cls = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/cpu_control_seq.sv
// Registered Moore control sequencer for the mini CPU: one microstep per
// clock, memory-ready wait states, pause between instructions and halt.
module cpu_control_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int IR_W   = 32,
   parameter int OPC_W  = 5,
   parameter bit MEM_HS = 1'b1
) (
   input  logic             Clock,
   input  logic             Reset,
   cpu_control_seq_if.slave bus
);

   state_t          state_reg, state_next, fetch_entry;
   op_class_t       cls_reg, dec_cls;
   logic            illegal_reg, con_reg, mem_hold;
   logic [OPC_W-1:0] opc;
   logic            ir_low_unused;
   strobe_t         strb;

   assign opc           = bus.IR[IR_W-1 -: OPC_W];
   assign ir_low_unused = ^bus.IR[IR_W-OPC_W-1:0];

   cpu_op_class #(.OPC_W(OPC_W)) u_op_class (
      .opc (opc),
      .cls (dec_cls)
   );

   assign mem_hold    = MEM_HS && is_mem_step(state_reg, cls_reg) && !bus.Mem_ready;
   assign fetch_entry = bus.Stop ? S_PAUSE : S_F0;

   // The instruction class is captured when F3 is left so later IR changes are ignored.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_reg   <= S_RST;
         cls_reg     <= C_NOP;
         illegal_reg <= 1'b0;
         con_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         con_reg     <= bus.Con_FF;
         illegal_reg <= (state_reg == S_F3) && (dec_cls == C_ILLEGAL);
         if (state_reg == S_F3) begin
            cls_reg <= dec_cls;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      if (!mem_hold) begin
         case (state_reg)
            S_RST, S_PAUSE: state_next = fetch_entry;
            S_HALT:         state_next = S_HALT;
            S_F0:           state_next = S_F1;
            S_F1:           state_next = S_F2;
            S_F2:           state_next = S_F3;
            S_F3: begin
               case (dec_cls)
                  C_NOP, C_ILLEGAL: state_next = fetch_entry;
                  C_HALT:           state_next = S_HALT;
                  default:          state_next = S_T3;
               endcase
            end
            S_T3: begin
               case (cls_reg)
                  C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: state_next = fetch_entry;
                  C_UNARY:                           state_next = S_T5;
                  default:                           state_next = S_T4;
               endcase
            end
            S_T4: state_next = (cls_reg == C_JAL) ? fetch_entry : S_T5;
            S_T5: begin
               case (cls_reg)
                  C_ALU_R, C_ALU_I, C_UNARY, C_LDI: state_next = fetch_entry;
                  default:                          state_next = S_T6;
               endcase
            end
            S_T6: state_next = (cls_reg == C_MULDIV || cls_reg == C_BR) ? fetch_entry : S_T7;
            S_T7: state_next = fetch_entry;
            default: state_next = S_RST;
         endcase
      end
   end

   always_comb begin
      strb = '0;
      case (state_reg)
         S_F0: begin strb.pcout = 1'b1; strb.marin = 1'b1; strb.incpc = 1'b1; strb.zlowin = 1'b1; end
         S_F1: begin strb.zlowout = 1'b1; strb.pcin = 1'b1; end
         S_F2: begin strb.read = 1'b1; strb.mdrin = 1'b1; end
         S_F3: begin strb.mdrout = 1'b1; strb.irin = 1'b1; end
         S_T3: begin
            case (cls_reg)
               C_ALU_R, C_ALU_I: begin strb.grb = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1; end
               C_UNARY: begin
                  strb.grb = 1'b1; strb.rout = 1'b1; strb.zlowin = 1'b1; strb.zhighin = 1'b1;
               end
               C_MULDIV: begin strb.gra = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1; end
               C_LD, C_LDI, C_ST: begin strb.grb = 1'b1; strb.baout = 1'b1; strb.yin = 1'b1; end
               C_BR:   begin strb.gra = 1'b1; strb.rout = 1'b1; strb.conin = 1'b1; end
               C_JR:   begin strb.gra = 1'b1; strb.rout = 1'b1; strb.pcin = 1'b1; end
               C_JAL:  begin strb.pcout = 1'b1; strb.rin = 1'b1; strb.lnk = 1'b1; end
               C_IN:   begin strb.inportout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
               C_OUT:  begin strb.gra = 1'b1; strb.rout = 1'b1; strb.outportin = 1'b1; end
               C_MFHI: begin strb.hiout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
               C_MFLO: begin strb.loout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
               default: strb = '0;
            endcase
         end
         S_T4: begin
            case (cls_reg)
               C_ALU_R: begin
                  strb.grc = 1'b1; strb.rout = 1'b1; strb.zlowin = 1'b1; strb.zhighin = 1'b1;
               end
               C_ALU_I: begin strb.cout = 1'b1; strb.zlowin = 1'b1; strb.zhighin = 1'b1; end
               C_MULDIV: begin
                  strb.grb = 1'b1; strb.rout = 1'b1; strb.zlowin = 1'b1; strb.zhighin = 1'b1;
               end
               C_LD, C_LDI, C_ST: begin strb.cout = 1'b1; strb.zlowin = 1'b1; end
               C_BR:  begin strb.pcout = 1'b1; strb.yin = 1'b1; end
               C_JAL: begin strb.gra = 1'b1; strb.rout = 1'b1; strb.pcin = 1'b1; end
               default: strb = '0;
            endcase
         end
         S_T5: begin
            case (cls_reg)
               C_ALU_R, C_ALU_I, C_UNARY, C_LDI: begin
                  strb.zlowout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1;
               end
               C_MULDIV:   begin strb.zlowout = 1'b1; strb.loin = 1'b1; end
               C_LD, C_ST: begin strb.zlowout = 1'b1; strb.marin = 1'b1; end
               C_BR:       begin strb.cout = 1'b1; strb.zlowin = 1'b1; end
               default: strb = '0;
            endcase
         end
         S_T6: begin
            case (cls_reg)
               C_MULDIV: begin strb.zhighout = 1'b1; strb.hiin = 1'b1; end
               C_LD:     begin strb.read = 1'b1; strb.mdrin = 1'b1; end
               C_ST:     begin strb.gra = 1'b1; strb.rout = 1'b1; strb.mdrin = 1'b1; end
               // Branch target is taken only when the condition flag is set.
               C_BR:     begin strb.zlowout = 1'b1; strb.pcin = con_reg; end
               default: strb = '0;
            endcase
         end
         S_T7: begin
            case (cls_reg)
               C_LD: begin strb.mdrout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
               C_ST: strb.write = 1'b1;
               default: strb = '0;
            endcase
         end
         default: strb = '0;
      endcase
   end

   assign bus.Clear   = (state_reg == S_RST);
   assign bus.Run     = !(state_reg == S_RST || state_reg == S_PAUSE || state_reg == S_HALT);
   assign bus.Illegal = illegal_reg;

   assign bus.Gra       = strb.gra;
   assign bus.Grb       = strb.grb;
   assign bus.Grc       = strb.grc;
   assign bus.Rin       = strb.rin;
   assign bus.Rout      = strb.rout;
   assign bus.BAout     = strb.baout;
   assign bus.Cout      = strb.cout;
   assign bus.Lnk       = strb.lnk;
   assign bus.PCout     = strb.pcout;
   assign bus.PCin      = strb.pcin;
   assign bus.IncPC     = strb.incpc;
   assign bus.MARin     = strb.marin;
   assign bus.MDRin     = strb.mdrin;
   assign bus.MDRout    = strb.mdrout;
   assign bus.IRin      = strb.irin;
   assign bus.Yin       = strb.yin;
   assign bus.Zlowin    = strb.zlowin;
   assign bus.Zhighin   = strb.zhighin;
   assign bus.Zlowout   = strb.zlowout;
   assign bus.Zhighout  = strb.zhighout;
   assign bus.HIin      = strb.hiin;
   assign bus.HIout     = strb.hiout;
   assign bus.LOin      = strb.loin;
   assign bus.LOout     = strb.loout;
   assign bus.CONin     = strb.conin;
   assign bus.InPortout = strb.inportout;
   assign bus.OutPortin = strb.outportin;
   assign bus.Read      = strb.read;
   assign bus.Write     = strb.write;

endmodule

// File: tb/tb_cpu_control_seq.sv
// Bench for cpu_control_seq: a per-instruction step list built from the
// instruction rules is compared with the strobes every clock.
module tb_cpu_control_seq;

   localparam logic [28:0] M_W    = 29'd1 << 0,  M_RD   = 29'd1 << 1,  M_OPI  = 29'd1 << 2;
   localparam logic [28:0] M_INO  = 29'd1 << 3,  M_CONI = 29'd1 << 4,  M_LOO  = 29'd1 << 5;
   localparam logic [28:0] M_LOI  = 29'd1 << 6,  M_HIO  = 29'd1 << 7,  M_HII  = 29'd1 << 8;
   localparam logic [28:0] M_ZHO  = 29'd1 << 9,  M_ZLO  = 29'd1 << 10, M_ZHI  = 29'd1 << 11;
   localparam logic [28:0] M_ZLI  = 29'd1 << 12, M_YI   = 29'd1 << 13, M_IRI  = 29'd1 << 14;
   localparam logic [28:0] M_MDRO = 29'd1 << 15, M_MDRI = 29'd1 << 16, M_MARI = 29'd1 << 17;
   localparam logic [28:0] M_INC  = 29'd1 << 18, M_PCI  = 29'd1 << 19, M_PCO  = 29'd1 << 20;
   localparam logic [28:0] M_LNK  = 29'd1 << 21, M_COUT = 29'd1 << 22, M_BAO  = 29'd1 << 23;
   localparam logic [28:0] M_ROUT = 29'd1 << 24, M_RIN  = 29'd1 << 25, M_GRC  = 29'd1 << 26;
   localparam logic [28:0] M_GRB  = 29'd1 << 27, M_GRA  = 29'd1 << 28;
   localparam logic [31:0] RSTV   = {1'b0, 1'b1, 1'b0, 29'd0};

   typedef struct {
      logic [28:0] strb;
      logic        illg, clear, run;
      logic [31:0] ir;
      logic        mrdy, stop, con;
   } cyc_t;

   logic        Clock = 1'b0;
   logic        rst1, rst0;
   logic [31:0] ir_d;
   logic        con_d, mrdy_d, stop_d;
   cyc_t        q[$];
   logic        pend_illg, br_hold, br_con;
   string       cur_tag;
   int          vectors, miscompares;

   always #5 Clock = ~Clock;

   cpu_control_seq_if #(.IR_W(32)) b1 ();
   cpu_control_seq_if #(.IR_W(32)) b0 ();

   assign b1.IR = ir_d;  assign b1.Con_FF = con_d;  assign b1.Mem_ready = mrdy_d;  assign b1.Stop = stop_d;
   assign b0.IR = ir_d;  assign b0.Con_FF = con_d;  assign b0.Mem_ready = mrdy_d;  assign b0.Stop = stop_d;

   cpu_control_seq #(.IR_W(32), .OPC_W(5), .MEM_HS(1'b1)) dut1 (.Clock(Clock), .Reset(rst1), .bus(b1));
   cpu_control_seq #(.IR_W(32), .OPC_W(5), .MEM_HS(1'b0)) dut0 (.Clock(Clock), .Reset(rst0), .bus(b0));

   wire [31:0] obs1 = {b1.Illegal, b1.Clear, b1.Run, b1.Gra, b1.Grb, b1.Grc, b1.Rin, b1.Rout, b1.BAout,
                       b1.Cout, b1.Lnk, b1.PCout, b1.PCin, b1.IncPC, b1.MARin, b1.MDRin, b1.MDRout,
                       b1.IRin, b1.Yin, b1.Zlowin, b1.Zhighin, b1.Zlowout, b1.Zhighout, b1.HIin,
                       b1.HIout, b1.LOin, b1.LOout, b1.CONin, b1.InPortout, b1.OutPortin, b1.Read, b1.Write};
   wire [31:0] obs0 = {b0.Illegal, b0.Clear, b0.Run, b0.Gra, b0.Grb, b0.Grc, b0.Rin, b0.Rout, b0.BAout,
                       b0.Cout, b0.Lnk, b0.PCout, b0.PCin, b0.IncPC, b0.MARin, b0.MDRin, b0.MDRout,
                       b0.IRin, b0.Yin, b0.Zlowin, b0.Zhighin, b0.Zlowout, b0.Zhighout, b0.HIin,
                       b0.HIout, b0.LOin, b0.LOout, b0.CONin, b0.InPortout, b0.OutPortin, b0.Read, b0.Write};

   task automatic check(input int sel, input logic [31:0] exp, input string tag);
      logic [31:0] got;
      got = (sel != 0) ? obs1 : obs0;
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s vec %0d: got %h expected %h", tag, vectors, got, exp);
      end
   endtask

   task automatic push(input logic [28:0] s, input logic run, input logic clr,
                       input logic mr, input logic [31:0] ir);
      cyc_t r;
      r.strb = s;  r.run = run;  r.clear = clr;  r.illg = pend_illg;  pend_illg = 1'b0;
      r.ir = ir;   r.mrdy = mr;  r.stop = 1'($urandom);
      r.con = br_hold ? br_con : 1'($urandom);
      q.push_back(r);
   endtask

   task automatic set_last_stop(input logic v);
      cyc_t r;
      r = q.pop_back();
      r.stop = v;
      q.push_back(r);
   endtask

   task automatic step(input logic [28:0] s);
      push(s, 1'b1, 1'b0, 1'($urandom), $urandom);
   endtask

   task automatic mem(input logic [28:0] s, input int w, input int hs);
      if (hs != 0) begin
         for (int i = 0; i < w; i++) push(s, 1'b1, 1'b0, 1'b0, $urandom);
         push(s, 1'b1, 1'b0, 1'b1, $urandom);
      end else begin
         push(s, 1'b1, 1'b0, (w == 0), $urandom);
      end
   endtask

   task automatic start_rst();
      pend_illg = 1'b0;
      br_hold   = 1'b0;
      push(29'd0, 1'b0, 1'b1, 1'($urandom), $urandom);
      set_last_stop(1'b0);
   endtask

   // wf/wx: memory wait cycles in fetch/execute, p: pause cycles after the instruction
   task automatic instr(input int opc, input int wf, input int wx, input logic con,
                        input int p, input int hs);
      logic [4:0]  o5;
      logic [31:0] irw;
      o5      = 5'(opc);
      irw     = {o5, 27'($urandom)};
      cur_tag = $sformatf("op%0d", opc);
      br_hold = (opc == 19);
      br_con  = con;
      step(M_PCO | M_MARI | M_INC | M_ZLI);
      step(M_ZLO | M_PCI);
      mem(M_RD | M_MDRI, wf, hs);
      push(M_MDRO | M_IRI, 1'b1, 1'b0, 1'($urandom), irw);
      if (opc >= 3 && opc <= 11) begin
         step(M_GRB | M_ROUT | M_YI); step(M_GRC | M_ROUT | M_ZLI | M_ZHI); step(M_ZLO | M_GRA | M_RIN);
      end else if (opc >= 12 && opc <= 14) begin
         step(M_GRB | M_ROUT | M_YI); step(M_COUT | M_ZLI | M_ZHI); step(M_ZLO | M_GRA | M_RIN);
      end else if (opc == 17 || opc == 18) begin
         step(M_GRB | M_ROUT | M_ZLI | M_ZHI); step(M_ZLO | M_GRA | M_RIN);
      end else if (opc == 15 || opc == 16) begin
         step(M_GRA | M_ROUT | M_YI); step(M_GRB | M_ROUT | M_ZLI | M_ZHI);
         step(M_ZLO | M_LOI); step(M_ZHO | M_HII);
      end else if (opc == 0) begin
         step(M_GRB | M_BAO | M_YI); step(M_COUT | M_ZLI); step(M_ZLO | M_MARI);
         mem(M_RD | M_MDRI, wx, hs); step(M_MDRO | M_GRA | M_RIN);
      end else if (opc == 1) begin
         step(M_GRB | M_BAO | M_YI); step(M_COUT | M_ZLI); step(M_ZLO | M_GRA | M_RIN);
      end else if (opc == 2) begin
         step(M_GRB | M_BAO | M_YI); step(M_COUT | M_ZLI); step(M_ZLO | M_MARI);
         step(M_GRA | M_ROUT | M_MDRI); mem(M_W, wx, hs);
      end else if (opc == 19) begin
         step(M_GRA | M_ROUT | M_CONI); step(M_PCO | M_YI); step(M_COUT | M_ZLI);
         step(M_ZLO | (con ? M_PCI : 29'd0));
      end else if (opc == 20) step(M_GRA | M_ROUT | M_PCI);
      else if (opc == 21) begin step(M_PCO | M_RIN | M_LNK); step(M_GRA | M_ROUT | M_PCI); end
      else if (opc == 22) step(M_INO | M_GRA | M_RIN);
      else if (opc == 23) step(M_GRA | M_ROUT | M_OPI);
      else if (opc == 24) step(M_HIO | M_GRA | M_RIN);
      else if (opc == 25) step(M_LOO | M_GRA | M_RIN);

      if (opc == 27) begin
         for (int i = 0; i < 10; i++) push(29'd0, 1'b0, 1'b0, 1'($urandom), $urandom);
      end else begin
         if (opc > 27) pend_illg = 1'b1;
         set_last_stop(p > 0);
         for (int i = 0; i < p; i++) begin
            push(29'd0, 1'b0, 1'b0, 1'($urandom), $urandom);
            set_last_stop(i < p - 1);
         end
      end
   endtask

   // Called at a falling edge; leaves 'leave' records unconsumed.
   task automatic run_q(input int sel, input int leave);
      cyc_t r;
      while (q.size() > leave) begin
         r = q.pop_front();
         #1;
         check(sel, {r.illg, r.clear, r.run, r.strb}, cur_tag);
         ir_d = r.ir;  mrdy_d = r.mrdy;  stop_d = r.stop;  con_d = r.con;
         @(negedge Clock);
      end
   endtask

   initial begin
      ir_d = '0;  con_d = 1'b0;  mrdy_d = 1'b1;  stop_d = 1'b0;
      rst1 = 1'b0;  rst0 = 1'b0;  pend_illg = 1'b0;  br_hold = 1'b0;  br_con = 1'b0;
      vectors = 0;  miscompares = 0;  cur_tag = "reset";
      #1 rst1 = 1'b1;  rst0 = 1'b1;
      #1 check(1, RSTV, "reset_hs1");  check(0, RSTV, "reset_hs0");
      @(negedge Clock);
      rst1 = 1'b0;
      start_rst();

      instr(3, 0, 0, 1'b0, 0, 1);
      instr(0, 0, 3, 1'b0, 0, 1);
      instr(0, 0, 0, 1'b1, 0, 1);
      instr(19, 0, 0, 1'b0, 0, 1);
      instr(19, 0, 0, 1'b1, 0, 1);
      instr(15, 0, 0, 1'b0, 2, 1);
      instr(31, 0, 0, 1'b0, 0, 1);
      instr(26, 1, 0, 1'b0, 0, 1);
      instr(28, 0, 0, 1'b0, 1, 1);
      instr(21, 0, 0, 1'b0, 0, 1);
      run_q(1, 0);

      for (int k = 0; k < 40; k++) begin
         int o;
         o = $urandom_range(0, 31);
         if (o == 27) o = 26;
         instr(o, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1);
         run_q(1, 0);
      end

      instr(2, 0, 3, 1'b0, 0, 1);
      run_q(1, 2);
      mrdy_d = 1'b0;
      #1 check(1, {3'b001, M_W}, "st_T7_write");
      #2 rst1 = 1'b1;
      #1 check(1, RSTV, "st_T7_async_reset");
      q.delete();
      @(negedge Clock);
      rst1 = 1'b0;
      start_rst();
      instr(6, 0, 0, 1'b0, 0, 1);
      instr(27, 0, 0, 1'b0, 0, 1);
      run_q(1, 0);
      #3 rst1 = 1'b1;
      #1 check(1, RSTV, "halt_reset");
      @(negedge Clock);
      rst1 = 1'b0;
      start_rst();
      instr(12, 0, 0, 1'b0, 0, 1);
      run_q(1, 0);

      rst1 = 1'b1;
      rst0 = 1'b0;
      start_rst();
      instr(0, 2, 3, 1'b0, 0, 0);
      instr(2, 1, 2, 1'b0, 0, 0);
      instr(3, 0, 0, 1'b0, 1, 0);
      instr(24, 0, 0, 1'b0, 0, 0);
      run_q(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_control_seq.md
# cpu_control_seq

Cycle-accurate, synthesizable control sequencer for the mini CPU datapath, replacing the delay-based control unit. A registered Moore FSM issues one microstep per clock, supports parametrised opcode field placement, a memory-ready handshake with optional wait states, a pause input and a true halt state. It sits between the IR and the datapath control strobes.

## Interface
- IR_W, 32, instruction width.
- OPC_W, 5, opcode width; opcode = IR[IR_W-1 -: OPC_W].
- MEM_HS, 1, 1 = Read/Write steps hold until Mem_ready; 0 = Mem_ready ignored, one cycle per memory step.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IR  in  IR_W  current instruction register.
- Con_FF  in  1  branch condition flag.
- Mem_ready  in  1  memory completion; sampled in memory steps.
- Stop  in  1  pause request.
- Clear  out  1  datapath clear.
- Run  out  1  high while executing.
- Illegal  out  1  one-cycle pulse on an undefined opcode.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout, Lnk  out  1 each  register-file select/enable; Lnk forces R15 as write target.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, CONin, InPortout, OutPortin, Read, Write  out  1 each  datapath strobes.

## Operation
- Reset asynchronous, active-high; one clock; no internal delays.
- Outputs decoded only from the state register; strobes not listed for a step are 0.
- RST: Clear=1, Run=0. After Reset falls, one RST cycle, then F0.
- Fetch: F0 PCout MARin IncPC Zlowin; F1 Zlowout PCin; F2 Read MDRin (memory step); F3 MDRout IRin; then decode.
- ALU reg (add sub and or shl shr shra rol ror): T3 Grb Rout Yin; T4 Grc Rout Zlowin Zhighin; T5 Zlowout Gra Rin.
- ALU imm (addi andi ori): T3 Grb Rout Yin; T4 Cout Zlowin Zhighin; T5 as above.
- not/neg: T3 Grb Rout Zlowin Zhighin; T5.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout Zlowin Zhighin; T5 Zlowout LOin; T6 Zhighout HIin.
- ld: T3 Grb BAout Yin; T4 Cout Zlowin; T5 Zlowout MARin; T6 Read MDRin (memory step); T7 MDRout Gra Rin.
- ldi: T3, T4 as ld; T5 Zlowout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin; T7 Write (memory step).
- br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zlowin; T6 Zlowout, PCin = Con_FF.
- jr: T3 Gra Rout PCin. jal: T3 PCout Rin Lnk; T4 Gra Rout PCin.
- in: T3 InPortout Gra Rin. out: T3 Gra Rout OutPortin. mfhi/mflo: T3 HIout/LOout Gra Rin.
- nop: back to F0. halt: HALT, Run=0, all strobes 0, left only by Reset.
- Undefined opcode: Illegal=1 for the decode-exit cycle, treated as nop.
- Memory step, MEM_HS=1: state and strobes hold while Mem_ready=0; advance on the clock where Mem_ready=1. MEM_HS=0: one cycle.
- Stop: sampled on every transition into F0; if 1, enter PAUSE (Run=0, strobes 0) instead; PAUSE→F0 on the first clock with Stop=0. Instructions are never split.

## Timing
- Run=1 in every state except RST, PAUSE, HALT.
- Zero-wait latency, F0 to next F0: fetch 4; ALU reg/imm 7; not/neg 6; mul/div 8; ld 9; ldi 7; st 9; br 8; jr, in, out, mfhi, mflo 5; jal 6; nop 4.
- Each memory wait cycle adds 1.
- Decode uses IR as registered at end of F3; IR changes at other times have no effect.
- Reset mid-instruction: all strobes (incl. Read/Write) drop to 0 and Clear rises asynchronously; no partial step completes.
- Stop and halt in the same decode: halt wins.

## Structure
- Package cpu_ctrl_pkg: opcode constants (ld=0, ldi=1, st=2, add=3 … halt=27), state enum, op-class enum.
- Sub-module cpu_op_class: combinational opcode → class decode (ALU_R, ALU_I, UNARY, MULDIV, LD, LDI, ST, BR, JR, JAL, IN, OUT, MFHI, MFLO, NOP, HALT, ILLEGAL).

## Test plan
- Reset pulse then add r1,r2,r3 (opcode 3), Mem_ready=1: Clear one cycle, fetch strobes F0–F3, T3–T5 exact; next F0 exactly 7 cycles after first F0.
- ld with Mem_ready low 3 cycles in T6 (MEM_HS=1): Read/MDRin held 4 cycles, T7 follows; total 12 cycles. MEM_HS=0: 9 cycles.
- br with Con_FF=0 then Con_FF=1: PCin=0 vs PCin=1 in T6.
- Stop=1 during mul: mul completes T6, PAUSE with Run=0; Stop=0 → F0 next clock.
- halt (opcode 27): Run=0 forever, strobes 0; only Reset restarts at RST.
- Reset asserted during st T7 with Write=1: Write drops immediately, Clear=1; opcode 31: Illegal pulse, next F0 after 4 cycles.
